// File: rtl/friscv_pkg.sv
// friscv_pkg: shared constants and types for the friscv instruction-memory path.
//   ARCH             - datapath word width
//   IMEM_ADDR_WIDTH  - imem byte-address width
//   IMEM_DEPTH       - imem depth in words
//   LOADER_LEN_BYTES - number of little-endian bytes in the image length header
//   loader_state_t   - state encoding of friscv_imem_loader
package friscv_pkg;

  localparam int ARCH             = 32;
  localparam int IMEM_ADDR_WIDTH  = 12;
  localparam int IMEM_DEPTH       = 1024;
  localparam int LOADER_LEN_BYTES = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEN   = 3'd1,
    DATA  = 3'd2,
    WRITE = 3'd3,
    CHK   = 3'd4,
    DONE  = 3'd5,
    ERROR = 3'd6
  } loader_state_t;

endpackage

// File: rtl/friscv_byte_packer.sv
// friscv_byte_packer: shifts bytes in little-endian order into a word.
//   clk, rst      - clock, synchronous active-high reset
//   clear_i       - drop any partial word and restart at byte 0
//   shift_i       - accept byte_i this cycle
//   byte_i        - incoming byte
//   word_o        - registered word (complete the cycle after full_o)
//   word_next_o   - word including byte_i, valid while full_o is high
//   full_o        - this shift supplies the last byte of a word
module friscv_byte_packer
  import friscv_pkg::*;
#(
  parameter int DATA_W = ARCH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_i,
  input  logic              shift_i,
  input  logic [7:0]        byte_i,
  output logic [DATA_W-1:0] word_o,
  output logic [DATA_W-1:0] word_next_o,
  output logic              full_o
);

  logic [DATA_W-1:0] word_q, word_d;
  logic [1:0]        cnt_q, cnt_d;

  // New bytes enter at the top; after four shifts byte 0 sits in [7:0].
  assign word_next_o = {byte_i, word_q[DATA_W-1:8]};
  assign full_o      = shift_i && (cnt_q == 2'd3);
  assign word_o      = word_q;

  always_comb begin
    word_d = word_q;
    cnt_d  = cnt_q;
    if (clear_i) begin
      word_d = '0;
      cnt_d  = 2'd0;
    end else if (shift_i) begin
      word_d = word_next_o;
      cnt_d  = cnt_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      word_q <= '0;
      cnt_q  <= 2'd0;
    end else begin
      word_q <= word_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/friscv_imem_loader.sv
// friscv_imem_loader: boot-time imem writer. Receives a 4-byte little-endian
// word count followed by the payload words, writes each word to imem at
// consecutive word-aligned byte addresses and holds the core in reset until
// the image is complete.
//   clk, rst       - clock, synchronous active-high reset
//   start_i        - begin a load (accepted in IDLE/DONE/ERROR)
//   byte_i/_valid_i, byte_ready_o - byte stream handshake
//   imem_we_o/addr_o/wdata_o      - imem write port
//   core_hold_o    - core reset hold
//   done_o/error_o - load status levels
// Optional build macro FRISCV_LOADER_CHECKSUM_EN: expect one trailing XOR
// checksum byte over the payload and check it in CHK.
module friscv_imem_loader
  import friscv_pkg::*;
#(
  parameter int IMEM_ADDR_W = IMEM_ADDR_WIDTH,
  parameter int IMEM_WORDS  = IMEM_DEPTH,
  parameter int DATA_W      = ARCH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_i,
  input  logic [7:0]             byte_i,
  input  logic                   byte_valid_i,
  output logic                   byte_ready_o,
  output logic                   imem_we_o,
  output logic [IMEM_ADDR_W-1:0] imem_addr_o,
  output logic [DATA_W-1:0]      imem_wdata_o,
  output logic                   core_hold_o,
  output logic                   done_o,
  output logic                   error_o
);

  localparam int WCNT_W = $clog2(IMEM_WORDS) + 1;

  loader_state_t     state_q, state_d;
  logic [WCNT_W-1:0] word_cnt_q, word_cnt_d;
  logic [DATA_W-1:0] len_q, len_d;

  logic              accept;
  logic              pk_clear;
  logic              pk_shift;
  logic              pk_full;
  logic [DATA_W-1:0] pk_word;
  logic [DATA_W-1:0] pk_word_next;
  logic [DATA_W-1:0] word_cnt_inc;

`ifdef FRISCV_LOADER_CHECKSUM_EN
  logic [7:0] csum_q, csum_d;
`endif

  assign byte_ready_o = (state_q == LEN) || (state_q == DATA) || (state_q == CHK);
  assign accept       = byte_valid_i && byte_ready_o;
  assign pk_shift     = accept && ((state_q == LEN) || (state_q == DATA));
  assign word_cnt_inc = DATA_W'(word_cnt_q) + DATA_W'(1);

  friscv_byte_packer #(
    .DATA_W (DATA_W)
  ) u_packer (
    .clk         (clk),
    .rst         (rst),
    .clear_i     (pk_clear),
    .shift_i     (pk_shift),
    .byte_i      (byte_i),
    .word_o      (pk_word),
    .word_next_o (pk_word_next),
    .full_o      (pk_full)
  );

  always_comb begin
    state_d    = state_q;
    word_cnt_d = word_cnt_q;
    len_d      = len_q;
    pk_clear   = 1'b0;
`ifdef FRISCV_LOADER_CHECKSUM_EN
    csum_d     = csum_q;
`endif
    case (state_q)
      IDLE, DONE, ERROR: begin
        if (start_i) begin
          state_d    = LEN;
          word_cnt_d = '0;
          pk_clear   = 1'b1;
`ifdef FRISCV_LOADER_CHECKSUM_EN
          csum_d     = 8'h00;
`endif
        end
      end
      LEN: begin
        // Decide on the full length including the byte arriving now.
        if (pk_full) begin
          len_d = pk_word_next;
          if (pk_word_next == '0)
            state_d = DONE;
          else if (pk_word_next > DATA_W'(IMEM_WORDS))
            state_d = ERROR;
          else
            state_d = DATA;
        end
      end
      DATA: begin
`ifdef FRISCV_LOADER_CHECKSUM_EN
        if (accept)
          csum_d = csum_q ^ byte_i;
`endif
        if (pk_full)
          state_d = WRITE;
      end
      WRITE: begin
        word_cnt_d = word_cnt_q + WCNT_W'(1);
        if (word_cnt_inc == len_q)
`ifdef FRISCV_LOADER_CHECKSUM_EN
          state_d = CHK;
`else
          state_d = DONE;
`endif
        else
          state_d = DATA;
      end
      CHK: begin
`ifdef FRISCV_LOADER_CHECKSUM_EN
        if (accept)
          state_d = (byte_i == csum_q) ? DONE : ERROR;
`else
        state_d = ERROR;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      word_cnt_q <= '0;
      len_q      <= '0;
`ifdef FRISCV_LOADER_CHECKSUM_EN
      csum_q     <= 8'h00;
`endif
    end else begin
      state_q    <= state_d;
      word_cnt_q <= word_cnt_d;
      len_q      <= len_d;
`ifdef FRISCV_LOADER_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  assign imem_we_o    = (state_q == WRITE);
  assign imem_addr_o  = {word_cnt_q[IMEM_ADDR_W-3:0], 2'b00};
  assign imem_wdata_o = pk_word;
  assign core_hold_o  = (state_q != DONE);
  assign done_o       = (state_q == DONE);
  assign error_o      = (state_q == ERROR);

endmodule

// File: tb/tb_friscv_imem_loader.sv
// tb_friscv_imem_loader: directed bench for friscv_imem_loader. Expected imem
// writes are queued as stimulus is issued; a monitor pops and compares them
// on every write strobe. Status levels are compared directly.
module tb_friscv_imem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [7:0]  byte_i;
  logic        byte_valid_i;
  logic        byte_ready_o;
  logic        imem_we_o;
  logic [11:0] imem_addr_o;
  logic [31:0] imem_wdata_o;
  logic        core_hold_o;
  logic        done_o;
  logic        error_o;

  typedef struct packed {
    logic [11:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t  exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  logic [7:0] tb_csum;
  bit   gaps = 1'b0;

  always #5 clk = ~clk;

  friscv_imem_loader dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .byte_i       (byte_i),
    .byte_valid_i (byte_valid_i),
    .byte_ready_o (byte_ready_o),
    .imem_we_o    (imem_we_o),
    .imem_addr_o  (imem_addr_o),
    .imem_wdata_o (imem_wdata_o),
    .core_hold_o  (core_hold_o),
    .done_o       (done_o),
    .error_o      (error_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Write monitor: every strobe must match the head of the expected queue.
  always @(negedge clk) begin
    if (!rst && imem_we_o) begin
      check("ready_low_in_write", {31'd0, byte_ready_o}, 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_write_addr", {20'd0, imem_addr_o}, 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("write_addr", {20'd0, imem_addr_o}, {20'd0, e.addr});
        check("write_data", imem_wdata_o, e.data);
      end
    end
  end

  // Called and returns on a negedge; the transfer happens at the posedge in between.
  task automatic send_byte(input logic [7:0] b);
    int n;
    if (gaps) begin
      n = $urandom_range(0, 2);
      for (int i = 0; i < n; i++) @(negedge clk);
    end
    byte_i       = b;
    byte_valid_i = 1'b1;
    n = 0;
    while (!byte_ready_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      check("byte_accept_timeout", 32'd0, 32'd1);
    end else begin
      @(negedge clk);
    end
    byte_valid_i = 1'b0;
  endtask

  task automatic send_len(input logic [31:0] len);
    for (int k = 0; k < 4; k++) send_byte(len[8*k +: 8]);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) begin
      tb_csum = tb_csum ^ w[8*k +: 8];
      send_byte(w[8*k +: 8]);
    end
  endtask

  task automatic expect_write(input int idx, input logic [31:0] w);
    wr_t e;
    e.addr = 12'(idx << 2);
    e.data = w;
    exp_q.push_back(e);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    tb_csum = 8'h00;
  endtask

  // After the last payload byte: finish the WRITE (and the checksum byte).
  task automatic finish_image();
`ifdef FRISCV_LOADER_CHECKSUM_EN
    send_byte(tb_csum);
`else
    @(negedge clk);
`endif
  endtask

  initial begin
    rst          = 1'b1;
    start_i      = 1'b0;
    byte_i       = 8'h00;
    byte_valid_i = 1'b0;
    tb_csum      = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_ready", {31'd0, byte_ready_o}, 32'd0);
    check("rst_we",    {31'd0, imem_we_o},    32'd0);
    check("rst_addr",  {20'd0, imem_addr_o},  32'd0);
    check("rst_wdata", imem_wdata_o,          32'd0);
    check("rst_hold",  {31'd0, core_hold_o},  32'd1);
    check("rst_done",  {31'd0, done_o},       32'd0);
    check("rst_error", {31'd0, error_o},      32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_ready", {31'd0, byte_ready_o}, 32'd0);

    // Nominal two-word load
    pulse_start();
    check("len_ready", {31'd0, byte_ready_o}, 32'd1);
    expect_write(0, 32'h1234_5678);
    expect_write(1, 32'hDEAD_BEEF);
    send_len(32'd2);
    send_word(32'h1234_5678);
    send_word(32'hDEAD_BEEF);
    finish_image();
    check("nom_done", {31'd0, done_o},      32'd1);
    check("nom_hold", {31'd0, core_hold_o}, 32'd0);
    check("nom_drain", exp_q.size(),        32'd0);

    // Zero length from DONE
    pulse_start();
    check("restart_done_clr", {31'd0, done_o},      32'd0);
    check("restart_hold",     {31'd0, core_hold_o}, 32'd1);
    send_len(32'd0);
    check("zero_done", {31'd0, done_o}, 32'd1);
    repeat (3) @(negedge clk);

    // Oversize length 1025
    pulse_start();
    send_len(32'd1025);
    check("over_error", {31'd0, error_o},      32'd1);
    check("over_hold",  {31'd0, core_hold_o},  32'd1);
    check("over_ready", {31'd0, byte_ready_o}, 32'd0);
    repeat (3) @(negedge clk);
    pulse_start();
    check("err_clear", {31'd0, error_o}, 32'd0);

    // Full 1024-word image, already in LEN after the start above
    for (int i = 0; i < 1024; i++) expect_write(i, 32'h0101_0101 * i ^ 32'h5A00_00C3);
    send_len(32'd1024);
    for (int i = 0; i < 1024; i++) send_word(32'h0101_0101 * i ^ 32'h5A00_00C3);
    finish_image();
    check("full_done",  {31'd0, done_o}, 32'd1);
    check("full_drain", exp_q.size(),    32'd0);

    // Backpressure: random idle gaps on the byte stream
    gaps = 1'b1;
    pulse_start();
    expect_write(0, 32'hCAFE_F00D);
    expect_write(1, 32'h0BAD_C0DE);
    expect_write(2, 32'h8001_7FFE);
    send_len(32'd3);
    send_word(32'hCAFE_F00D);
    send_word(32'h0BAD_C0DE);
    send_word(32'h8001_7FFE);
    gaps = 1'b0;
    finish_image();
    check("bp_done",  {31'd0, done_o}, 32'd1);
    check("bp_drain", exp_q.size(),    32'd0);

    // Reset in DATA after two bytes, then a clean one-word load
    pulse_start();
    send_len(32'd1);
    send_byte(8'h11);
    send_byte(8'h22);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_hold",  {31'd0, core_hold_o},  32'd1);
    check("mid_rst_ready", {31'd0, byte_ready_o}, 32'd0);
    check("mid_rst_done",  {31'd0, done_o},       32'd0);
    rst = 1'b0;
    pulse_start();
    expect_write(0, 32'hA5A5_A5A5);
    send_len(32'd1);
    send_word(32'hA5A5_A5A5);
    finish_image();
    check("mid_rst_load_done", {31'd0, done_o}, 32'd1);
    check("mid_rst_drain",     exp_q.size(),    32'd0);

`ifdef FRISCV_LOADER_CHECKSUM_EN
    pulse_start();
    expect_write(0, 32'h1234_5678);
    send_len(32'd1);
    send_word(32'h1234_5678);
    send_byte(8'h08);
    check("csum_ok_done", {31'd0, done_o}, 32'd1);
    pulse_start();
    expect_write(0, 32'h1234_5678);
    send_len(32'd1);
    send_word(32'h1234_5678);
    send_byte(8'h00);
    check("csum_bad_error", {31'd0, error_o},     32'd1);
    check("csum_bad_hold",  {31'd0, core_hold_o}, 32'd1);
    check("csum_drain",     exp_q.size(),         32'd0);
`endif

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
